// File: rtl/adc_hex_tx_if.sv
// Sample-in / character-out handshake bundle for adc_hex_tx.
// master = sample source and UART side (drives strobes and done), slave = adc_hex_tx.
interface adc_hex_tx_if #(
    parameter int DW      = 12,
    parameter int FIFO_AW = 2
);
    logic               sample_valid;
    logic [DW-1:0]      sample_data;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_done_tick;
    logic               overflow_clr;
    logic               overflow;
    logic               busy;
    logic [FIFO_AW:0]   fifo_level;

    modport master (
        output sample_valid, sample_data, tx_done_tick, overflow_clr,
        input  tx_start, tx_data, overflow, busy, fifo_level
    );

    modport slave (
        input  sample_valid, sample_data, tx_done_tick, overflow_clr,
        output tx_start, tx_data, overflow, busy, fifo_level
    );
endinterface

// File: rtl/adc_hex_tx.sv
// ADC sample FIFO feeding a UART TX with upper-case ASCII hex lines, MSD first.
// Define ADC_HEX_CRLF_EN to end each line with CR LF instead of LF alone.
module adc_hex_tx #(
    parameter int DW      = 12,
    parameter int FIFO_AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    adc_hex_tx_if.slave  bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int NCHAR = (DW + 3) / 4;
`ifdef ADC_HEX_CRLF_EN
    localparam int LAST  = NCHAR + 1;
`else
    localparam int LAST  = NCHAR;
`endif
    localparam int IDX_W = $clog2(LAST + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          mem_q [DEPTH];
    logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]       level_q, level_d;
    logic [DW-1:0]          sample_q, sample_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   tx_start_q, tx_start_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   overflow_q, overflow_d;

    logic                   full, push, pop, drop;
    logic [DW-1:0]          char_src;
    logic [IDX_W-1:0]       char_idx;
    logic [4*NCHAR-1:0]     src_pad;
    logic [3:0]             nib_arr [NCHAR];
    logic [3:0]             nib;
    logic [7:0]             char_val;

    assign full = (level_q == (FIFO_AW+1)'(DEPTH));
    assign pop  = (state_q == IDLE) && (level_q != '0);
    assign push = bus.sample_valid && (!full || pop);
    assign drop = bus.sample_valid && !push;

    // The character being loaded is either the first one of the head sample
    // (leaving IDLE) or the next one of the held sample (leaving WAIT).
    assign char_src = (state_q == IDLE) ? mem_q[rd_ptr_q] : sample_q;
    assign char_idx = (state_q == IDLE) ? '0 : idx_q + IDX_W'(1);
    assign src_pad  = (4*NCHAR)'(char_src);

    generate
        for (genvar gi = 0; gi < NCHAR; gi++) begin : g_nib
            assign nib_arr[gi] = src_pad[4*(NCHAR-1-gi) +: 4];
        end
    endgenerate

    always_comb begin
        nib      = 4'h0;
        char_val = 8'h0A;
        for (int k = 0; k < NCHAR; k++) begin
            if (char_idx == IDX_W'(k)) nib = nib_arr[k];
        end
        if (char_idx < IDX_W'(NCHAR)) begin
            char_val = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
`ifdef ADC_HEX_CRLF_EN
        end else if (char_idx == IDX_W'(NCHAR)) begin
            char_val = 8'h0D;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sample_d   = sample_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    sample_d   = mem_q[rd_ptr_q];
                    idx_d      = '0;
                    tx_start_d = 1'b1;
                    tx_data_d  = char_val;
                    state_d    = SEND;
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (bus.tx_done_tick) begin
                    if (idx_q < IDX_W'(LAST)) begin
                        idx_d      = idx_q + IDX_W'(1);
                        tx_start_d = 1'b1;
                        tx_data_d  = char_val;
                        state_d    = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + FIFO_AW'(push);
        rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);
        level_d    = level_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        overflow_d = overflow_q;
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) overflow_d = 1'b1;
        else if (bus.overflow_clr) overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sample_q   <= '0;
            idx_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sample_q   <= sample_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.sample_data;
    end

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_adc_hex_tx.sv
// Randomized and directed bench for adc_hex_tx against a queue-based line model.
module tb_adc_hex_tx;
    localparam int DW      = 12;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 4;
    localparam int NCHAR   = 3;
`ifdef ADC_HEX_CRLF_EN
    localparam bit CRLF    = 1'b1;
`else
    localparam bit CRLF    = 1'b0;
`endif
    localparam int LINE_LEN = NCHAR + (CRLF ? 2 : 1);

    typedef logic [7:0] bq_t[$];

    logic clk   = 1'b0;
    logic reset = 1'b1;

    adc_hex_tx_if #(.DW(DW), .FIFO_AW(FIFO_AW)) bus ();

    adc_hex_tx #(.DW(DW), .FIFO_AW(FIFO_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Text a sample should appear as on the wire.
    function automatic bq_t make_line(input int s);
        bq_t l;
        int d;
        l = {};
        for (int k = 0; k < NCHAR; k++) begin
            d = (s >> (4 * (NCHAR - 1 - k))) & 15;
            l.push_back((d < 10) ? 8'(48 + d) : 8'(65 + d - 10));
        end
        if (CRLF) l.push_back(8'h0D);
        l.push_back(8'h0A);
        return l;
    endfunction

    // Reference model: sample queue, character queue of the line in flight.
    int          m_q[$];
    bq_t         m_line;
    bit          m_busy = 0, m_wait = 0, m_start = 0, m_ovf = 0;
    logic [7:0]  m_data = 8'h00;

    always @(posedge clk) begin : ref_model
        bit pop, push, drop, was_start;
        if (reset) begin
            m_q.delete(); m_line = {};
            m_busy = 0; m_wait = 0; m_start = 0; m_data = 8'h00; m_ovf = 0;
        end else begin
            pop  = !m_busy && (m_q.size() > 0);
            push = bus.sample_valid && ((m_q.size() < DEPTH) || pop);
            drop = bus.sample_valid && !push;
            was_start = m_start;
            m_start = 0;
            if (pop) begin
                m_line  = make_line(m_q.pop_front());
                m_busy  = 1; m_wait = 0; m_start = 1;
                m_data  = m_line.pop_front();
            end else if (m_busy) begin
                if (was_start) m_wait = 1;
                else if (m_wait && bus.tx_done_tick) begin
                    m_wait = 0;
                    if (m_line.size() > 0) begin
                        m_start = 1;
                        m_data  = m_line.pop_front();
                    end else begin
                        m_busy = 0;
                    end
                end
            end
            if (push) m_q.push_back(int'(bus.sample_data));
            if (drop) m_ovf = 1;
            else if (bus.overflow_clr) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        check_eq("tx_start",   32'(bus.tx_start),   32'(m_start));
        check_eq("tx_data",    32'(bus.tx_data),    32'(m_data));
        check_eq("busy",       32'(bus.busy),       32'(m_busy));
        check_eq("fifo_level", 32'(bus.fifo_level), m_q.size());
        check_eq("overflow",   32'(bus.overflow),   32'(m_ovf));
    end

    // UART responder plus input driver; called at a falling edge, returns at the next one.
    int  done_cnt = 0;
    bq_t seen;

    task automatic step(input bit valid, input int data, input bit clr, input bit rst, input bit fdone);
        bit d;
        d = 0;
        if (bus.tx_start === 1'b1) seen.push_back(bus.tx_data);
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) d = 1;
        end
        if (bus.tx_start === 1'b1) done_cnt = 3;
        if (rst) done_cnt = 0;
        bus.tx_done_tick = d | fdone;
        bus.sample_valid = valid;
        bus.sample_data  = DW'(data);
        bus.overflow_clr = clr;
        reset            = rst;
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!(bus.busy == 1'b0 && bus.fifo_level == '0 && bus.tx_start == 1'b0) && n < budget) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        check_eq({tag, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic compare_seen(input string tag, input bq_t e);
        check_eq({tag, "_len"}, seen.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            if (i < seen.size()) check_eq(tag, 32'(seen[i]), 32'(e[i]));
    endtask

    initial begin
        bq_t exp_l;
        int  n;
        bus.sample_valid = 0; bus.sample_data = '0;
        bus.tx_done_tick = 0; bus.overflow_clr = 0;
        @(negedge clk);
        check_eq("rst_busy",  32'(bus.busy), 32'd0);
        check_eq("rst_level", 32'(bus.fifo_level), 32'd0);
        check_eq("rst_data",  32'(bus.tx_data), 32'd0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Single samples with literal expected text
        seen = {};
        step(1, 'hA5F, 0, 0, 0);
        wait_idle("t1", 200);
        exp_l = '{8'h41, 8'h35, 8'h46};
        if (CRLF) exp_l.push_back(8'h0D);
        exp_l.push_back(8'h0A);
        compare_seen("t1_char", exp_l);

        seen = {};
        step(1, 'h007, 0, 0, 0);
        wait_idle("t2", 200);
        exp_l = '{8'h30, 8'h30, 8'h37};
        if (CRLF) exp_l.push_back(8'h0D);
        exp_l.push_back(8'h0A);
        compare_seen("t2_char", exp_l);
        check_eq("t2_level", 32'(bus.fifo_level), 32'd0);

        // Five strobes while idle: none dropped, order preserved
        seen = {};
        for (int i = 1; i <= 5; i++) step(1, i, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_eq("t3_ovf", 32'(bus.overflow), 32'd0);
        wait_idle("t3", 600);
        exp_l = {};
        for (int i = 1; i <= 5; i++) exp_l = {exp_l, make_line(i)};
        compare_seen("t3_char", exp_l);

        // Six strobes while busy with an empty FIFO
        step(1, 'h111, 0, 0, 0);
        idle_steps(2);
        for (int i = 0; i < 6; i++) step(1, 'h200 + i, 0, 0, 0);
        check_eq("t4_ovf",   32'(bus.overflow), 32'd1);
        check_eq("t4_level", 32'(bus.fifo_level), 32'd4);
        step(0, 0, 1, 0, 0);
        check_eq("t4_clr",   32'(bus.overflow), 32'd0);

        // Strobe while full in the cycle IDLE pops
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin step(0, 0, 0, 0, 0); n++; end
        check_eq("t5_timeout", 32'(n < 200), 32'd1);
        check_eq("t5_full",  32'(bus.fifo_level), 32'd4);
        step(1, 'h3AB, 0, 0, 0);
        check_eq("t5_level", 32'(bus.fifo_level), 32'd4);
        check_eq("t5_ovf",   32'(bus.overflow), 32'd0);
        wait_idle("t5", 800);

        // Reset during the wait for the second character
        seen = {};
        step(1, 'h9C4, 0, 0, 0);
        n = 0;
        while (seen.size() < 2 && n < 100) begin step(0, 0, 0, 0, 0); n++; end
        check_eq("t6_timeout", 32'(n < 100), 32'd1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check_eq("t6_start", 32'(bus.tx_start), 32'd0);
        check_eq("t6_busy",  32'(bus.busy), 32'd0);
        check_eq("t6_level", 32'(bus.fifo_level), 32'd0);
        step(0, 0, 0, 0, 1);
        idle_steps(4);
        seen = {};
        check_eq("t6_late",  32'(bus.busy), 32'd0);
        step(1, 'hBEE, 0, 0, 0);
        wait_idle("t6", 200);
        compare_seen("t6_char", make_line('hBEE));
        check_eq("t6_len", LINE_LEN, seen.size());

        // Random traffic, spurious done ticks, occasional clears and resets
        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 5) == 0, int'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 999) == 0, $urandom_range(0, 30) == 0);
        wait_idle("rand", 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
